// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file defaults and the writeback source select type.
package rf_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  typedef enum logic {WB_ALU = 1'b0, WB_MEM = 1'b1} wb_sel_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits; writeback clears, then allocation sets.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_LK = NUM_RD_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_add,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_add,
  input  logic [NUM_LK*AW-1:0] lk_add,
  output logic [NUM_LK-1:0]    lk_busy,
  output logic [NREGS-1:0]     busy_vec
);
  logic [NREGS-1:0] busy_nxt;
  // set after clear so a same-cycle reallocation keeps the register pending
  always_comb begin
    busy_nxt = busy_vec;
    if (clr_en) busy_nxt[clr_add] = 1'b0;
    if (set_en && set_add != '0) busy_nxt[set_add] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_vec <= '0;
    else busy_vec <= busy_nxt;
  always_comb begin
    lk_busy = '0;
    for (int p = 0; p < NUM_LK; p++) lk_busy[p] = busy_vec[lk_add[p*AW +: AW]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with registered reads and busy scoreboard.
// Define RF_BYPASS_EN to forward a same-edge writeback into matching reads.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_add,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_valid,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_add,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   memtoreg,
  input  logic [XLEN-1:0]        meminp,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_add,
  output logic [NREGS-1:0]       busy_vec
);
  logic [XLEN-1:0]   regs [NREGS];
  logic [XLEN-1:0]   wv;
  logic              wr_hit;
  logic [NUM_RD-1:0] lk_busy;
  wb_sel_e           wb_sel;
  assign wb_sel = wb_sel_e'(memtoreg);
  assign wv     = (wb_sel == WB_MEM) ? meminp : wr_data;
  assign wr_hit = wr_en && wr_add != '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wr_hit) regs[wr_add] <= wv;
  rf_scoreboard #(.NREGS(NREGS), .NUM_LK(NUM_RD)) u_sb (
    .clk(clk),
    .rst(rst),
    .clr_en(wr_en),
    .clr_add(wr_add),
    .set_en(alloc_en),
    .set_add(alloc_add),
    .lk_add(rd_add),
    .lk_busy(lk_busy),
    .busy_vec(busy_vec)
  );
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            byp;
    logic [XLEN-1:0] q;
    logic            b, v;
    assign ra = rd_add[p*AW +: AW];
`ifdef RF_BYPASS_EN
    assign byp = wr_hit && ra == wr_add;
`else
    assign byp = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        q <= '0;
        b <= 1'b0;
        v <= 1'b0;
      end else begin
        v <= rd_en[p];
        if (rd_en[p]) begin
          q <= (ra == '0) ? '0 : byp ? wv : regs[ra];
          b <= ra != '0 && !byp && lk_busy[p];
        end
      end
    assign rd_data[p*XLEN +: XLEN] = q;
    assign rd_busy[p]              = b;
    assign rd_valid[p]             = v;
  end
endmodule
